// File: rtl/ir_assembler.sv
// Instruction register assembler: gathers four 7-bit fetch beats into a 28-bit
// instruction, commits it on the fourth beat and decodes the committed word.
module ir_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ir_write,
  input  logic [6:0]  mem_data,
  input  logic        flush,
  output logic [27:0] instr,
  output logic [4:0]  opcode,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [3:0]  rd,
  output logic [27:0] imm_sext,
  output logic        instr_valid,
  output logic        seq_err,
  output logic [7:0]  instr_count
);

  // State encoding matches the ir_write code of the awaited beat.
  typedef enum logic [2:0] {
    B1 = 3'd1,
    B2 = 3'd2,
    B3 = 3'd3,
    B4 = 3'd4
  } beat_e;

  beat_e       exp_beat, exp_beat_n;
  logic [27:0] staging, staging_n;
  logic [27:0] instr_n;
  logic        valid_n, err_n;
  logic [7:0]  count_n;
  logic        beat_wr, in_order;

  assign beat_wr  = (ir_write != 3'd0) && !flush;
  assign in_order = beat_wr && (ir_write == exp_beat);

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_beat    <= B1;
      staging     <= 28'd0;
      instr       <= 28'd0;
      instr_valid <= 1'b0;
      seq_err     <= 1'b0;
      instr_count <= 8'd0;
    end else begin
      exp_beat    <= exp_beat_n;
      staging     <= staging_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
      seq_err     <= err_n;
      instr_count <= count_n;
    end
  end

  // Out-of-order beats only raise seq_err; everything else holds.
  always_comb begin
    exp_beat_n = exp_beat;
    staging_n  = staging;
    instr_n    = instr;
    valid_n    = instr_valid;
    err_n      = seq_err;
    count_n    = instr_count;
    if (flush) begin
      exp_beat_n = B1;
      staging_n  = 28'd0;
      valid_n    = 1'b0;
      err_n      = 1'b0;
    end else if (in_order) begin
      case (exp_beat)
        B1: begin
          staging_n  = {mem_data, 21'd0};
          valid_n    = 1'b0;
          exp_beat_n = B2;
        end
        B2: begin
          staging_n[20:14] = mem_data;
          exp_beat_n       = B3;
        end
        B3: begin
          staging_n[13:7] = mem_data;
          exp_beat_n      = B4;
        end
        B4: begin
          staging_n[6:0] = mem_data;
          instr_n        = {staging[27:7], mem_data};
          valid_n        = 1'b1;
          count_n        = instr_count + 8'd1;
          exp_beat_n     = B1;
        end
        default: exp_beat_n = B1;
      endcase
    end else if (beat_wr) begin
      err_n = 1'b1;
    end
  end

  assign opcode   = instr[27:23];
  assign rs       = instr[22:19];
  assign rt       = instr[18:15];
  assign rd       = instr[14:11];
  assign imm_sext = {{13{instr[14]}}, instr[14:0]};

endmodule

// File: tb/tb_ir_assembler.sv
// Self-checking bench for ir_assembler: directed scenarios plus random beats
// compared against a beat-array reference model.
module tb_ir_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ir_write;
  logic [6:0]  mem_data;
  logic        flush;
  logic [27:0] instr;
  logic [4:0]  opcode;
  logic [3:0]  rs, rt, rd;
  logic [27:0] imm_sext;
  logic        instr_valid, seq_err;
  logic [7:0]  instr_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [6:0]  m_beats [4];
  int          m_exp;
  logic [27:0] m_instr;
  logic        m_valid, m_err;
  int          m_count;
  logic [27:0] word_a;

  always #5 clk = ~clk;

  ir_assembler dut (
    .clk(clk), .reset(reset), .ir_write(ir_write), .mem_data(mem_data),
    .flush(flush), .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .imm_sext(imm_sext), .instr_valid(instr_valid), .seq_err(seq_err),
    .instr_count(instr_count)
  );

  function automatic logic [27:0] sextOf(input logic [27:0] w);
    int v;
    v = int'(w & 28'h7FFF);
    if (v >= 16384) v = v - 32768;
    return 28'(v);
  endfunction

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input logic r, input logic f, input logic [2:0] iw, input logic [6:0] d);
    if (r) begin
      foreach (m_beats[i]) m_beats[i] = 7'd0;
      m_exp = 1; m_instr = 28'd0; m_valid = 1'b0; m_err = 1'b0; m_count = 0;
    end else if (f) begin
      foreach (m_beats[i]) m_beats[i] = 7'd0;
      m_exp = 1; m_valid = 1'b0; m_err = 1'b0;
    end else if (iw != 3'd0) begin
      if (int'(iw) == m_exp) begin
        if (iw == 3'd1) begin
          foreach (m_beats[i]) m_beats[i] = 7'd0;
          m_valid = 1'b0;
        end
        m_beats[iw - 1] = d;
        if (iw == 3'd4) begin
          m_instr = (28'(m_beats[0]) << 21) + (28'(m_beats[1]) << 14) +
                    (28'(m_beats[2]) << 7) + 28'(d);
          m_valid = 1'b1;
          m_count = (m_count + 1) % 256;
        end
        m_exp = (m_exp % 4) + 1;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic [2:0] iw, input logic [6:0] d);
    @(negedge clk);
    reset = r; flush = f; ir_write = iw; mem_data = d;
    @(posedge clk);
    #1;
    modelStep(r, f, iw, d);
    reset = 1'b0; flush = 1'b0; ir_write = 3'd0;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".instr"}, instr, m_instr);
    check({tag, ".valid"}, 28'(instr_valid), 28'(m_valid));
    check({tag, ".seq_err"}, 28'(seq_err), 28'(m_err));
    check({tag, ".count"}, 28'(instr_count), 28'(m_count));
    check({tag, ".opcode"}, 28'(opcode), (m_instr >> 23) & 28'h1F);
    check({tag, ".rs"}, 28'(rs), (m_instr >> 19) & 28'hF);
    check({tag, ".rt"}, 28'(rt), (m_instr >> 15) & 28'hF);
    check({tag, ".rd"}, 28'(rd), (m_instr >> 11) & 28'hF);
    check({tag, ".imm"}, imm_sext, sextOf(m_instr));
  endtask

  task automatic fetchWord(input logic [27:0] w);
    applyStimulus(1'b0, 1'b0, 3'd1, w[27:21]);
    applyStimulus(1'b0, 1'b0, 3'd2, w[20:14]);
    applyStimulus(1'b0, 1'b0, 3'd3, w[13:7]);
    applyStimulus(1'b0, 1'b0, 3'd4, w[6:0]);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; ir_write = 3'd0; mem_data = 7'd0;
    m_exp = 1; m_instr = 28'd0; m_valid = 1'b0; m_err = 1'b0; m_count = 0;
    foreach (m_beats[i]) m_beats[i] = 7'd0;

    // Reset, also overriding a coincident flush and beat write
    applyStimulus(1'b1, 1'b1, 3'd1, 7'h55);
    checkOutput("reset");
    check("reset.imm_zero", imm_sext, 28'd0);

    // In-order fetch; previous instr holds until beat 4
    applyStimulus(1'b0, 1'b0, 3'd1, 7'h2A);
    checkOutput("inord.b1");
    applyStimulus(1'b0, 1'b0, 3'd2, 7'h11);
    applyStimulus(1'b0, 1'b0, 3'd3, 7'h55);
    checkOutput("inord.b3");
    applyStimulus(1'b0, 1'b0, 3'd4, 7'h7F);
    checkOutput("inord.b4");
    check("inord.instr_const", instr, 28'h5446AFF);
    check("inord.opcode_const", 28'(opcode), 28'h0A);
    check("inord.rs_const", 28'(rs), 28'h8);
    check("inord.rt_const", 28'(rt), 28'h8);
    check("inord.rd_const", 28'(rd), 28'hD);
    check("inord.imm_const", imm_sext, 28'hFFFEAFF);
    check("inord.count_const", 28'(instr_count), 28'd1);

    // Idle cycle changes nothing
    applyStimulus(1'b0, 1'b0, 3'd0, 7'h33);
    checkOutput("idle");

    // Out-of-order beat, then in-order recovery with sticky error
    applyStimulus(1'b0, 1'b0, 3'd1, 7'h03);
    applyStimulus(1'b0, 1'b0, 3'd3, 7'h44);
    checkOutput("ooo.err");
    applyStimulus(1'b0, 1'b0, 3'd2, 7'h12);
    applyStimulus(1'b0, 1'b0, 3'd3, 7'h23);
    applyStimulus(1'b0, 1'b0, 3'd4, 7'h34);
    checkOutput("ooo.commit");
    for (int c = 5; c <= 7; c++) begin
      applyStimulus(1'b0, 1'b0, 3'(c), 7'(c));
      checkOutput("ooo.illegal");
    end
    applyStimulus(1'b0, 1'b1, 3'd0, 7'd0);
    checkOutput("ooo.flush");

    // Flush coincident with beat 3 of B keeps A
    word_a = 28'($urandom);
    fetchWord(word_a);
    applyStimulus(1'b0, 1'b0, 3'd1, 7'($urandom));
    applyStimulus(1'b0, 1'b0, 3'd2, 7'($urandom));
    applyStimulus(1'b0, 1'b1, 3'd3, 7'($urandom));
    checkOutput("flush.mid");
    check("flush.keepA", instr, word_a);
    fetchWord(28'($urandom));
    checkOutput("flush.commitB");

    // Random beats against the model
    for (int n = 0; n < 400; n++) begin
      logic [2:0] iw;
      iw = ($urandom_range(0, 9) < 7) ? 3'(m_exp) : 3'($urandom_range(0, 7));
      applyStimulus(1'b0, ($urandom_range(0, 39) == 0), iw, 7'($urandom));
      if (n % 8 == 0) checkOutput("rand");
    end

    // 256 fetches after reset wrap the counter back to zero
    applyStimulus(1'b1, 1'b0, 3'd0, 7'd0);
    for (int n = 0; n < 256; n++) fetchWord(28'($urandom));
    checkOutput("wrap");
    check("wrap.count_zero", 28'(instr_count), 28'd0);
    check("wrap.valid", 28'(instr_valid), 28'd1);

    // Reset after beat 2 discards partial fetch
    applyStimulus(1'b0, 1'b0, 3'd1, 7'h7A);
    applyStimulus(1'b0, 1'b0, 3'd2, 7'h5B);
    applyStimulus(1'b1, 1'b0, 3'd0, 7'd0);
    checkOutput("rstmid");
    applyStimulus(1'b0, 1'b0, 3'd1, 7'h61);
    checkOutput("rstmid.b1");
    applyStimulus(1'b0, 1'b0, 3'd2, 7'h0F);
    applyStimulus(1'b0, 1'b0, 3'd3, 7'h70);
    applyStimulus(1'b0, 1'b0, 3'd4, 7'h01);
    checkOutput("rstmid.commit");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
